// File: rtl/tmds_decoder.sv
// TMDS receive decoder: 2-stage 10b->8b decode plus word-alignment FSM driving bitslip.
// Optional running-disparity check is built when TMDS_DISPARITY_CHECK_EN is defined.
module tmds_decoder #(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WIN   = 4096,
  parameter int LOCK_TIMEOUT = 8192,
  parameter int SLIP_SETTLE  = 16,
  parameter int DISP_LIMIT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic       c0,
  output logic       c1,
  output logic       video_active,
  output logic       locked,
  output logic       bitslip,
  output logic       disp_err
);

  localparam int MAX_A   = (SEARCH_WIN > LOCK_TIMEOUT) ? SEARCH_WIN : LOCK_TIMEOUT;
  localparam int MAX_B   = (CTRL_RUN > SLIP_SETTLE) ? CTRL_RUN : SLIP_SETTLE;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > DISP_LIMIT) ? MAX_C : DISP_LIMIT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] WIN_LAST    = CW'(SEARCH_WIN - 1);
  localparam logic [CW-1:0] IDLE_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SLIP_SETTLE - 1);
  localparam logic [CW-1:0] RUN_DONE    = CW'(CTRL_RUN);

  typedef enum logic [2:0] {SEARCH, CONFIRM, SLIP, SLIP_WAIT, LOCKED} state_t;

  logic [9:0]    s1_reg;
  logic [7:0]    data_reg;
  logic          c0_reg, c1_reg, video_reg;
  state_t        state_reg;
  logic          locked_reg, bitslip_reg;
  logic [CW-1:0] win_cnt_reg, run_cnt_reg, idle_cnt_reg, settle_cnt_reg;
  logic [CW-1:0] run_next;
  logic          tok_hit;
  logic [1:0]    tok_ctrl;
  logic [7:0]    d;
  logic [7:0]    dec;

  always_comb begin
    tok_hit  = 1'b1;
    tok_ctrl = 2'b00;
    case (s1_reg)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        tok_hit  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  assign d      = s1_reg[9] ? ~s1_reg[7:0] : s1_reg[7:0];
  assign dec[0] = d[0];
  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign dec[gi] = s1_reg[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg    <= '0;
      data_reg  <= '0;
      c0_reg    <= 1'b0;
      c1_reg    <= 1'b0;
      video_reg <= 1'b0;
    end else begin
      s1_reg <= tmds_in;
      if (tok_hit) begin
        video_reg         <= 1'b0;
        {c1_reg, c0_reg}  <= tok_ctrl;
      end else begin
        video_reg <= 1'b1;
        data_reg  <= dec;
      end
    end
  end

  assign run_next = (state_reg == CONFIRM) ? run_cnt_reg + CW'(1) : CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SEARCH;
      locked_reg     <= 1'b0;
      bitslip_reg    <= 1'b0;
      win_cnt_reg    <= '0;
      run_cnt_reg    <= '0;
      idle_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
    end else begin
      bitslip_reg <= 1'b0;
      case (state_reg)
        SEARCH, CONFIRM: begin
          if (win_cnt_reg != WIN_LAST) win_cnt_reg <= win_cnt_reg + CW'(1);
          // A token wins over a simultaneous window expiry.
          if (tok_hit) begin
            if (run_next == RUN_DONE) begin
              state_reg    <= LOCKED;
              locked_reg   <= 1'b1;
              run_cnt_reg  <= '0;
              idle_cnt_reg <= '0;
              win_cnt_reg  <= '0;
            end else begin
              state_reg   <= CONFIRM;
              run_cnt_reg <= run_next;
            end
          end else if (win_cnt_reg == WIN_LAST) begin
            state_reg   <= SLIP;
            bitslip_reg <= 1'b1;
            run_cnt_reg <= '0;
          end else if (state_reg == CONFIRM) begin
            state_reg   <= SEARCH;
            run_cnt_reg <= '0;
          end
        end
        SLIP: begin
          state_reg      <= SLIP_WAIT;
          settle_cnt_reg <= '0;
        end
        SLIP_WAIT: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg      <= SEARCH;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + CW'(1);
          end
        end
        LOCKED: begin
          if (tok_hit) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == IDLE_LAST) begin
            state_reg    <= SEARCH;
            locked_reg   <= 1'b0;
            idle_cnt_reg <= '0;
            win_cnt_reg  <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

`ifdef TMDS_DISPARITY_CHECK_EN
  localparam logic signed [7:0] DLIM = 8'(DISP_LIMIT);

  logic signed [5:0] disp_reg;
  logic              disp_err_reg;
  logic [3:0]        ones;
  logic signed [7:0] word_disp, disp_sum;
  logic              disp_over;

  assign ones      = 4'($countones(s1_reg));
  assign word_disp = $signed({3'b000, ones, 1'b0}) - 8'sd10;
  assign disp_sum  = $signed({{2{disp_reg[5]}}, disp_reg}) + word_disp;
  assign disp_over = (disp_sum > DLIM) || (disp_sum < -DLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg     <= '0;
      disp_err_reg <= 1'b0;
    end else if (tok_hit) begin
      disp_reg     <= '0;
      disp_err_reg <= 1'b0;
    end else if (locked_reg && disp_over) begin
      disp_reg     <= '0;
      disp_err_reg <= 1'b1;
    end else begin
      disp_reg     <= 6'(disp_sum);
      disp_err_reg <= 1'b0;
    end
  end

  assign disp_err = disp_err_reg;
`else
  assign disp_err = 1'b0;
`endif

  assign data_out     = data_reg;
  assign c0           = c0_reg;
  assign c1           = c1_reg;
  assign video_active = video_reg;
  assign locked       = locked_reg;
  assign bitslip      = bitslip_reg;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: a TMDS encoder model feeds random bytes, a token/run model checks
// control, data and lock behaviour; alignment, lock loss and disparity are directed phases.
module tb_tmds_decoder;

  localparam int SW = 4096;
  localparam int LT = 8192;
  localparam int SS = 16;
  localparam int CR = 8;
  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic       c0, c1, video_active, locked, bitslip, disp_err;

  always #5 clk = ~clk;

  tmds_decoder dut (
    .clk(clk), .rst(rst), .tmds_in(tmds_in), .data_out(data_out), .c0(c0), .c1(c1),
    .video_active(video_active), .locked(locked), .bitslip(bitslip), .disp_err(disp_err)
  );

  typedef struct {
    bit         tok;
    bit         dk;
    logic [1:0] c;
    logic [7:0] d;
  } exp_t;

  exp_t       hist[$];
  logic [1:0] m_c;
  logic [7:0] m_d;
  bit         m_dk;
  int         tok_run, vid_run;
  bit         lock_m, chk_lock, chk_slip;
  int         enc_cnt;
  int         cyc;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, expv, cyc);
    end
  endtask

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'b1101010100: return 0;
      10'b0010101011: return 1;
      10'b0101010100: return 2;
      10'b1010101011: return 3;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
    logic [19:0] t;
    t = {w, w};
    return t[19-k -: 10];
  endfunction

  // DVI transmit encoder with its own running disparity.
  task automatic encode(input logic [7:0] b, output logic [9:0] w);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(b);
    qm[0] = b[0];
    if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
    end
  endtask

  // Drive one word; check the outputs for the word driven two clocks earlier.
  task automatic step(input logic [9:0] w, input bit dk, input logic [7:0] d);
    exp_t e, o;
    int tc;
    tc = tok_code(w);
    e.tok = (tc >= 0);
    if (e.tok) m_c = 2'(tc);
    else begin
      m_dk = dk;
      m_d  = d;
    end
    e.c  = m_c;
    e.d  = m_d;
    e.dk = m_dk;
    hist.push_back(e);
    tmds_in = w;
    @(posedge clk);
    #1;
    cyc++;
    if (hist.size() >= 2) begin
      o = hist.pop_front();
      if (o.tok) begin
        tok_run++;
        vid_run = 0;
      end else begin
        vid_run++;
        tok_run = 0;
      end
      if (!lock_m && tok_run >= CR) lock_m = 1'b1;
      else if (lock_m && vid_run >= LT) lock_m = 1'b0;
      chk("video_active", video_active, !o.tok);
      chk("ctrl", {c1, c0}, o.c);
      if (o.dk) chk("data_out", data_out, o.d);
      if (chk_lock) chk("locked", locked, lock_m);
      if (chk_slip) chk("bitslip", bitslip, 0);
`ifndef TMDS_DISPARITY_CHECK_EN
      chk("disp_err", disp_err, 0);
`endif
    end
  endtask

  task automatic step_byte(input logic [7:0] b);
    logic [9:0] w;
    encode(b, w);
    step(w, 1'b1, b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tmds_in = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_data", data_out, 0);
    chk("rst_c0", c0, 0);
    chk("rst_c1", c1, 0);
    chk("rst_video", video_active, 0);
    chk("rst_locked", locked, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_disp_err", disp_err, 0);
    rst = 1'b0;
    hist.delete();
    m_c = 2'b00; m_d = '0; m_dk = 1'b0;
    tok_run = 0; vid_run = 0; lock_m = 1'b0; enc_cnt = 0;
  endtask

  initial begin
    int k, pulses, last;
    bit prev_slip, got_lock;
    logic [4:0] dseen;
    logic [7:0] dir_bytes[5];
    cyc = 0;
    chk_lock = 1'b1;
    chk_slip = 1'b1;

    // Reset, then continuous 00 tokens: lock on the 8th token.
    do_reset();
    $display("reset phase: outputs cleared");
    for (int i = 0; i < 12; i++) step(TOK00, 1'b0, 8'h00);
    $display("token phase: locked=%0b after 12 tokens", locked);

    // Directed and random data after a c1c0=11 token.
    step(TOK11, 1'b0, 8'h00);
    dir_bytes = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h10};
    for (int i = 0; i < 5; i++) begin
      step_byte(dir_bytes[i]);
      $display("data byte %02h driven", dir_bytes[i]);
    end
    for (int i = 0; i < 32; i++) step_byte(8'($urandom_range(0, 255)));
    $display("random data phase: 32 bytes");

    // Lock timeout: a token at word 8191 keeps lock, 8192 idle words drop it.
    step(TOK00, 1'b0, 8'h00);
    for (int i = 0; i < LT - 2; i++) step_byte(8'($urandom_range(0, 255)));
    step(TOK00, 1'b0, 8'h00);
    $display("lock-keep phase: locked=%0b", locked);
    for (int i = 0; i < LT; i++) step_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 12; i++) step(TOK00, 1'b0, 8'h00);
    $display("lock-loss phase: relocked=%0b", locked);

    // Confirm abort: 5 tokens, one data word, then 8+ tokens.
    do_reset();
    for (int i = 0; i < 5; i++) step(TOK00, 1'b0, 8'h00);
    step_byte(8'h3C);
    for (int i = 0; i < 12; i++) step(TOK00, 1'b0, 8'h00);
    $display("confirm-abort phase: locked=%0b", locked);

    // Alignment: stream rotated by 3, undo one bit per bitslip pulse.
    do_reset();
    chk_lock = 1'b0;
    chk_slip = 1'b0;
    k = 3; pulses = 0; last = 0; prev_slip = 1'b0; got_lock = 1'b0;
    for (int n = 0; n < 20000 && !got_lock; n++) begin
      step(rotl(TOK00, k), 1'b0, 8'h00);
      if (bitslip) begin
        chk("bitslip_width", prev_slip, 0);
        pulses++;
        if (pulses > 1) chk("slip_gap", cyc - last, SW + SS + 1);
        last = cyc;
        if (k > 0) k--;
        $display("bitslip pulse %0d at cycle %0d", pulses, cyc);
      end
      prev_slip = bitslip;
      if (locked) got_lock = 1'b1;
    end
    chk("slip_count", pulses, 3);
    chk("align_lock", got_lock, 1);
    lock_m = got_lock;
    tok_run = CR;
    chk_lock = 1'b1;
    chk_slip = 1'b1;
    for (int i = 0; i < 20; i++) step(TOK00, 1'b0, 8'h00);

    // All-ones words while locked: +10 each, limit exceeded on the second.
    for (int i = 0; i < 5; i++) begin
      step((i < 3) ? 10'h3FF : TOK00, 1'b0, 8'h00);
      dseen[i] = disp_err;
    end
`ifdef TMDS_DISPARITY_CHECK_EN
    chk("disp_err_seq", dseen, 5'b00100);
`else
    chk("disp_err_seq", dseen, 5'b00000);
`endif
    $display("disparity phase: disp_err samples=%05b", dseen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
